// File: rtl/data_mem_arb_pkg.sv
// Shared encodings for the data memory arbiter: FSM states and requester port indices.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_U = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the port not granted last.
module rr_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = PORT_C;
    case (req)
      2'b01:   winner = PORT_C;
      2'b10:   winner = PORT_U;
      2'b11:   winner = ~last;
      default: winner = PORT_C;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the core and UART sender ports onto a single-cycle data memory.
//
// state  | meaning
// IDLE   | waiting for a request; latches the winner's access on entry to ACCESS
// ACCESS | memory strobe driven from the latched access
// RESP   | winner's done pulses, read data forwarded, last-granted updated
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_stall,
  output logic              o_c_done,
  output logic [DATA_W-1:0] o_c_rdata,
  input  logic              i_u_req,
  input  logic              i_u_we,
  input  logic [ADDR_W-1:0] i_u_addr,
  input  logic [DATA_W-1:0] i_u_wdata,
  output logic              o_u_done,
  output logic [DATA_W-1:0] o_u_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t state;
  logic   last;
  logic   sel;
  logic   sel_we;
  logic   winner;

  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_pick2 u_pick (
    .req    ({i_u_req, i_c_req}),
    .last   (last),
    .winner (winner)
  );

  always_comb begin
    win_we    = i_c_we;
    win_addr  = i_c_addr;
    win_wdata = i_c_wdata;
    if (winner == PORT_U) begin
      win_we    = i_u_we;
      win_addr  = i_u_addr;
      win_wdata = i_u_wdata;
    end
  end

  // The memory address/data registers double as the latched copy of the winner's access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last        <= PORT_U;
      sel         <= PORT_C;
      sel_we      <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_c_done    <= 1'b0;
      o_u_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_c_req || i_u_req) begin
            sel         <= winner;
            sel_we      <= win_we;
            o_mem_addr  <= win_addr;
            o_mem_wdata <= win_wdata;
            o_mem_we    <= win_we;
            o_mem_re    <= ~win_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          o_mem_addr  <= '0;
          o_mem_wdata <= '0;
          o_mem_we    <= 1'b0;
          o_mem_re    <= 1'b0;
          o_c_done    <= (sel == PORT_C);
          o_u_done    <= (sel == PORT_U);
          state       <= RESP;
        end
        RESP: begin
          o_c_done <= 1'b0;
          o_u_done <= 1'b0;
          last     <= sel;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data arrives the cycle after the strobe, which is the done cycle.
  assign o_c_rdata = (o_c_done && !sel_we) ? i_mem_rdata : '0;
  assign o_u_rdata = (o_u_done && !sel_we) ? i_mem_rdata : '0;
  assign o_c_stall = i_c_req & ~o_c_done;

endmodule
